// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : keypad_pkg
// Brief    : Shared constants, report FSM encoding and key-set helpers for
//            the 4x4 keypad scanner.
// Revision : 1.0  initial release
// ============================================================================
package keypad_pkg;

    localparam int KEY_ROWS  = 4;
    localparam int KEY_COLS  = 4;
    localparam int KEY_COUNT = KEY_ROWS * KEY_COLS;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_MULTI = 2'd2;

    localparam logic [3:0] KEY_LEFT  = 4'd4;
    localparam logic [3:0] KEY_RIGHT = 4'd6;
    localparam logic [3:0] KEY_ROT   = 4'd1;
    localparam logic [3:0] KEY_DROP  = 4'd9;

    // Returns 0, 1 or 2 (meaning two or more keys)
    function automatic logic [1:0] key_count(input logic [KEY_COUNT-1:0] keys);
        logic [1:0] n;
        n = 2'd0;
        for (int i = 0; i < KEY_COUNT; i++) begin
            if (keys[i] && (n != 2'd2)) n = n + 2'd1;
        end
        return n;
    endfunction

    function automatic logic [3:0] key_index(input logic [KEY_COUNT-1:0] keys);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = KEY_COUNT - 1; i >= 0; i--) begin
            if (keys[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_matrix_scan_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Brief    : Two-flop synchronizer for asynchronous board inputs.
// Revision : 1.0  initial release
// ============================================================================
module sync_2ff #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule
`default_nettype wire

// File: rtl/keypad_matrix_scan.sv
`default_nettype none
// ============================================================================
// Module   : keypad_matrix_scan
// Brief    : 4x4 active-low key matrix scanner with whole-scan debounce and
//            single-key press reporting (ghosted combinations suppressed).
// Revision : 1.0  initial release
// ============================================================================
module keypad_matrix_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    output logic [3:0] col_out,
    input  logic [3:0] row_in,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int               c_div_w    = $clog2(SCAN_DIV);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(SCAN_DIV - 1);
    localparam logic [3:0]       c_deb      = 4'(DEBOUNCE_SCANS);

    logic [3:0]           w_rows_sync;
    logic [3:0]           w_pressed;
    logic [c_div_w-1:0]   r_div;
    logic [1:0]           r_col;
    logic [3:0]           r_col_out;
    logic [KEY_COUNT-1:0] r_snapshot;
    logic [KEY_COUNT-1:0] w_snap_next;
    logic                 r_scan_done;
    logic [KEY_COUNT-1:0] r_candidate;
    logic [KEY_COUNT-1:0] r_stable;
    logic [3:0]           r_deb_cnt;
    logic [1:0]           r_state;
    logic [3:0]           r_key_code;
    logic                 r_key_valid;

    logic                 w_sample;
    logic                 w_match;
    logic [3:0]           w_cnt_next;
    logic [KEY_COUNT-1:0] w_cand_next;
    logic                 w_stable_upd;
    logic [1:0]           w_nkeys;
    logic [3:0]           w_nidx;
    logic [1:0]           w_state_next;
    logic [3:0]           w_code_next;
    logic                 w_valid_next;

    sync_2ff #(
        .WIDTH     (4),
        .RESET_VAL (4'b1111)
    ) u_row_sync (
        .clk     (clk),
        .rst     (reset),
        .i_async (row_in),
        .o_sync  (w_rows_sync)
    );

    assign w_pressed = ~w_rows_sync;
    assign w_sample  = (r_div == c_div_last);

    always_comb begin
        w_snap_next = r_snapshot;
        for (int r = 0; r < KEY_ROWS; r++) begin
            for (int c = 0; c < KEY_COLS; c++) begin
                if (r_col == 2'(c)) w_snap_next[r*KEY_COLS + c] = w_pressed[r];
            end
        end
    end

    // Counter saturates at 15 so "first reach" is seen only once per run
    assign w_match     = (r_snapshot == r_candidate);
    assign w_cnt_next  = !w_match ? 4'd1 :
                         (r_deb_cnt == 4'hF) ? r_deb_cnt : r_deb_cnt + 4'd1;
    assign w_cand_next = w_match ? r_candidate : r_snapshot;
    assign w_stable_upd = r_scan_done && (w_cnt_next == c_deb) &&
                          (!w_match || (r_deb_cnt != c_deb)) &&
                          (w_cand_next != r_stable);

    assign w_nkeys = key_count(w_cand_next);
    assign w_nidx  = key_index(w_cand_next);

    // MULTI only leaves through a full release, so ghost chords never report
    always_comb begin
        w_state_next = r_state;
        w_code_next  = r_key_code;
        w_valid_next = 1'b0;
        if (w_stable_upd) begin
            case (r_state)
                ST_IDLE, ST_ONE: begin
                    if (w_nkeys == 2'd0) begin
                        w_state_next = ST_IDLE;
                    end else if (w_nkeys == 2'd1) begin
                        w_state_next = ST_ONE;
                        w_code_next  = w_nidx;
                        w_valid_next = 1'b1;
                    end else begin
                        w_state_next = ST_MULTI;
                    end
                end
                ST_MULTI: begin
                    if (w_nkeys == 2'd0) w_state_next = ST_IDLE;
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div       <= '0;
            r_col       <= 2'd0;
            r_col_out   <= 4'b1110;
            r_snapshot  <= '0;
            r_scan_done <= 1'b0;
            r_candidate <= '0;
            r_stable    <= '0;
            r_deb_cnt   <= 4'd0;
            r_state     <= ST_IDLE;
            r_key_code  <= 4'd0;
            r_key_valid <= 1'b0;
        end else begin
            r_scan_done <= w_sample && (r_col == 2'd3);
            if (w_sample) begin
                r_div      <= '0;
                r_col      <= r_col + 2'd1;
                r_col_out  <= {r_col_out[2:0], r_col_out[3]};
                r_snapshot <= w_snap_next;
            end else begin
                r_div <= r_div + c_div_w'(1);
            end
            if (r_scan_done) begin
                r_candidate <= w_cand_next;
                r_deb_cnt   <= w_cnt_next;
            end
            if (w_stable_upd) r_stable <= w_cand_next;
            r_state     <= w_state_next;
            r_key_code  <= w_code_next;
            r_key_valid <= w_valid_next;
        end
    end

    assign col_out   = r_col_out;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = (r_state == ST_ONE);

endmodule
`default_nettype wire

// File: tb/tb_keypad_matrix_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_matrix_scan
// Brief    : Directed and randomized bench for keypad_matrix_scan against a
//            scan-level reference model of debounce and press reporting.
// Revision : 1.0  initial release
// ============================================================================
module tb_keypad_matrix_scan;
    import keypad_pkg::*;

    localparam int c_div  = 8;
    localparam int c_deb  = 2;
    localparam int c_scan = 4 * c_div;

    logic        clk;
    logic        reset;
    logic [3:0]  col_out;
    logic [3:0]  row_in;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] r_pressed;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [3:0] got_codes[$];
    int         got_cyc[$];
    logic [3:0] exp_codes[$];

    // Reference model state: last snapshot, its run length, stable set,
    // and whether a multi-key chord is blocking reports until full release.
    logic [15:0] m_last;
    int          m_run;
    logic [15:0] m_stable;
    bit          m_blocked;
    logic        m_held;

    keypad_matrix_scan #(
        .SCAN_DIV       (c_div),
        .DEBOUNCE_SCANS (c_deb)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .col_out   (col_out),
        .row_in    (row_in),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!col_out[c] && r_pressed[r*4 + c]) row_in[r] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            got_codes.push_back(key_code);
            got_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last    = '0;
        m_run     = 0;
        m_stable  = '0;
        m_blocked = 1'b0;
        m_held    = 1'b0;
    endtask

    task automatic model_scan(input logic [15:0] snap);
        int n;
        if (snap == m_last) m_run++;
        else begin
            m_last = snap;
            m_run  = 1;
        end
        if (m_run == c_deb && snap != m_stable) begin
            m_stable = snap;
            n = $countones(snap);
            if (n == 0) m_blocked = 1'b0;
            else if (n >= 2) m_blocked = 1'b1;
            else if (!m_blocked) begin
                for (int i = 0; i < 16; i++)
                    if (snap[i]) exp_codes.push_back(4'(i));
            end
        end
        m_held = ($countones(m_stable) == 1) && !m_blocked;
    endtask

    task automatic scan(input logic [15:0] keys);
        r_pressed = keys;
        repeat (3) @(negedge clk);
        check("key_held", {31'd0, key_held}, {31'd0, m_held});
        repeat (c_scan - 3) @(negedge clk);
        model_scan(keys);
    endtask

    task automatic scans(input logic [15:0] keys, input int n);
        for (int i = 0; i < n; i++) scan(keys);
    endtask

    task automatic compare_events(input string tag);
        int n;
        check({tag, " strobe count"}, got_codes.size(), exp_codes.size());
        n = (got_codes.size() < exp_codes.size()) ? got_codes.size() : exp_codes.size();
        for (int i = 0; i < n; i++)
            check({tag, " key_code"}, {28'd0, got_codes[i]}, {28'd0, exp_codes[i]});
        got_codes.delete();
        got_cyc.delete();
        exp_codes.delete();
    endtask

    initial begin
        int t0;
        logic [15:0] k;
        int a, b;

        // Reset
        reset = 1'b1;
        r_pressed = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst col_out", {28'd0, col_out}, 32'hE);
        check("rst key_valid", {31'd0, key_valid}, 32'd0);
        check("rst key_held", {31'd0, key_held}, 32'd0);
        check("rst key_code", {28'd0, key_code}, 32'd0);
        reset = 1'b0;
        repeat (c_div - 1) @(negedge clk);
        check("col before step", {28'd0, col_out}, 32'hE);
        @(negedge clk);
        check("col after 8", {28'd0, col_out}, 32'hD);
        repeat (c_div) @(negedge clk);
        check("col after 16", {28'd0, col_out}, 32'hB);
        repeat (2 * c_div) @(negedge clk);
        check("col after 32", {28'd0, col_out}, 32'hE);
        model_scan('0);

        // Single press: row 1 low while column 2 driven
        t0 = cyc;
        scans(16'h0040, 5);
        check("press latency ok", {31'd0, (got_cyc.size() > 0) && (got_cyc[0] - t0 <= 3*c_scan + 3)}, 32'd1);
        scans(16'h0000, 3);
        check("code kept", {28'd0, key_code}, {28'd0, KEY_RIGHT});
        compare_events("single");

        // Bounce on key 9
        for (int i = 0; i < 4; i++) begin
            scan(16'h0001 << KEY_DROP);
            scan(16'h0000);
        end
        scans(16'h0000, 2);
        compare_events("bounce");

        // Ghosting: 0+15, then 0 alone, release, re-press 0
        scans(16'h8001, 4);
        scans(16'h0001, 3);
        scans(16'h0000, 3);
        compare_events("ghost");
        scans(16'h0001, 3);
        scans(16'h0000, 3);
        compare_events("ghost repress");

        // Slide from key 4 directly to key 5
        scans(16'h0001 << KEY_LEFT, 4);
        scans(16'h0020, 4);
        scans(16'h0000, 3);
        compare_events("slide");

        // Reset while key 3 is held
        scans(16'h0008, 3);
        repeat (10) @(negedge clk);
        check("pre-reset held", {31'd0, key_held}, {31'd0, m_held});
        compare_events("before reset");
        reset = 1'b1;
        @(negedge clk);
        check("midrst key_held", {31'd0, key_held}, 32'd0);
        check("midrst key_valid", {31'd0, key_valid}, 32'd0);
        check("midrst key_code", {28'd0, key_code}, 32'd0);
        check("midrst col_out", {28'd0, col_out}, 32'hE);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        scans(16'h0008, 3);
        scans(16'h0000, 3);
        compare_events("after reset");

        // Randomized key sequences
        for (int seg = 0; seg < 30; seg++) begin
            a = $urandom_range(0, 9);
            if (a < 4) k = '0;
            else if (a < 8) k = 16'h0001 << $urandom_range(0, 15);
            else begin
                a = $urandom_range(0, 15);
                b = (a + $urandom_range(1, 15)) % 16;
                k = (16'h0001 << a) | (16'h0001 << b);
            end
            scans(k, $urandom_range(1, 4));
        end
        scans(16'h0000, 3);
        compare_events("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
